// File: rtl/accel_pkg.sv
// Shared constants and FSM state type for the accelerator register-map sequencers.
package accel_pkg;

    localparam int DW        = 32;
    localparam int REG_AW    = 6;
    localparam int REG_COUNT = 48;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE
    } state_t;

endpackage

// File: rtl/dot_product_seq_if.sv
// Command/status handshake plus the register-map read/write ports of the dot-product sequencer.
interface dot_product_seq_if;
    import accel_pkg::*;

    logic              start;
    logic [REG_AW-1:0] a_base;
    logic [REG_AW-1:0] b_base;
    logic [REG_AW-1:0] len;
    logic [REG_AW-1:0] dst;
    logic              busy;
    logic              done;
    logic              err;
    logic [REG_AW-1:0] read_reg1;
    logic [REG_AW-1:0] read_reg2;
    logic [DW-1:0]     read_data1;
    logic [DW-1:0]     read_data2;
    logic [REG_AW-1:0] write_reg;
    logic              reg_write;
    logic [DW-1:0]     write_data;

    // Controller and register map together form the master side.
    modport master (
        output start, a_base, b_base, len, dst, read_data1, read_data2,
        input  busy, done, err, read_reg1, read_reg2, write_reg, reg_write, write_data
    );

    modport slave (
        input  start, a_base, b_base, len, dst, read_data1, read_data2,
        output busy, done, err, read_reg1, read_reg2, write_reg, reg_write, write_data
    );

endinterface

// File: rtl/dot_mac.sv
// Multiply-accumulate core: one registered product stage feeding a wrapping accumulator.
module dot_mac
    import accel_pkg::*;
#(
    parameter int DATA_W = DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              mul_en_i,
    input  logic              drain_en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] acc_o
);

    function automatic logic [DATA_W-1:0] mul_lo(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
        return x * y;
    endfunction

    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
        return x + y;
    endfunction

    logic [DATA_W-1:0] prod_p1_q, prod_p1_d;
    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    always_comb begin
        prod_p1_d = prod_p1_q;
        vld_p1_d  = vld_p1_q;
        acc_d     = acc_q;
        if (clr_i) begin
            prod_p1_d = '0;
            vld_p1_d  = 1'b0;
            acc_d     = '0;
        end else if (mul_en_i) begin
            prod_p1_d = mul_lo(a_i, b_i);
            vld_p1_d  = 1'b1;
            if (vld_p1_q) acc_d = add_wrap(acc_q, prod_p1_q);
        end else if (drain_en_i) begin
            if (vld_p1_q) acc_d = add_wrap(acc_q, prod_p1_q);
            vld_p1_d = 1'b0;
        end
    end

    // p1: product register; accumulator consumes it one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            prod_p1_q <= prod_p1_d;
            vld_p1_q  <= vld_p1_d;
            acc_q     <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/dot_product_seq.sv
// Reads two vectors from the register map, multiply-accumulates them and writes the
// 32-bit result back to a destination register.
module dot_product_seq
    import accel_pkg::*;
#(
    parameter int NREGS = REG_COUNT
) (
    input logic             clk,
    input logic             rst,
    dot_product_seq_if.slave bus
);

    localparam int AW = REG_AW;

    state_t          state_q;
    logic [AW-1:0]   a_base_q, b_base_q, len_q, dst_q, idx_q;
    logic            done_q, err_q;
    logic [AW:0]     a_end, b_end;
    logic            range_err;
    logic            accept;
    logic            in_run, in_write;
    logic [DW-1:0]   acc;

    // Sums are one bit wider so base+len up to 63+63 cannot wrap into range.
    always_comb begin
        a_end     = {1'b0, bus.a_base} + {1'b0, bus.len};
        b_end     = {1'b0, bus.b_base} + {1'b0, bus.len};
        range_err = (a_end > (AW+1)'(NREGS)) || (b_end > (AW+1)'(NREGS)) ||
                    ({1'b0, bus.dst} >= (AW+1)'(NREGS));
    end

    assign accept = (state_q == S_IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_base_q <= '0;
            b_base_q <= '0;
            len_q    <= '0;
            dst_q    <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_base_q <= bus.a_base;
                        b_base_q <= bus.b_base;
                        len_q    <= bus.len;
                        dst_q    <= bus.dst;
                        idx_q    <= '0;
                        err_q    <= range_err;
                        if (range_err) begin
                            done_q <= 1'b1;
                        end else if (bus.len == '0) begin
                            state_q <= S_WRITE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    idx_q <= idx_q + AW'(1);
                    if (idx_q == len_q - AW'(1)) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    state_q <= S_WRITE;
                    done_q  <= 1'b1;
                end
                S_WRITE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_run   = (state_q == S_RUN);
    assign in_write = (state_q == S_WRITE);

    dot_mac #(.DATA_W(DW)) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .mul_en_i   (in_run),
        .drain_en_i (state_q == S_DRAIN),
        .a_i        (bus.read_data1),
        .b_i        (bus.read_data2),
        .acc_o      (acc)
    );

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.read_reg1  = in_run ? a_base_q + idx_q : '0;
    assign bus.read_reg2  = in_run ? b_base_q + idx_q : '0;
    assign bus.reg_write  = in_write;
    assign bus.write_reg  = in_write ? dst_q : '0;
    assign bus.write_data = in_write ? acc : '0;

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed and randomized bench for dot_product_seq with a cycle-timeline reference model
// and a behavioural register map.
module tb_dot_product_seq;
    import accel_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_product_seq_if bus ();
    dot_product_seq dut (.clk(clk), .rst(rst), .bus(bus));

    // Register map: combinational reads, write at the clock edge.
    logic [DW-1:0] regs   [REG_COUNT];
    logic [DW-1:0] pl_arr [REG_COUNT];
    logic          pl_all = 1'b0;

    always @(posedge clk) begin
        if (pl_all) regs <= pl_arr;
        else if (bus.reg_write === 1'b1 && bus.write_reg < 6'd48) regs[bus.write_reg] <= bus.write_data;
    end
    assign bus.read_data1 = (bus.read_reg1 < 6'd48) ? regs[bus.read_reg1] : '0;
    assign bus.read_data2 = (bus.read_reg2 < 6'd48) ? regs[bus.read_reg2] : '0;

    // Reference model: c = number of clock edges seen; outputs are judged in the
    // cycle following edge c. An accepted start at edge T is busy for c = T..end.
    int            cyc = 0;
    bit            m_run = 0, m_err = 0;
    int            m_T = 0, m_end = -10, m_done = -10;
    int            m_len = 0, m_a = 0, m_b = 0, m_dst = 0;
    logic [DW-1:0] m_res = '0;

    function automatic bit exp_busy(int c);
        return m_run && c >= m_T && c <= m_end;
    endfunction

    always @(posedge clk) begin
        bit was_busy;
        was_busy = exp_busy(cyc);
        cyc = cyc + 1;
        if (rst) begin
            m_run  = 0;
            m_err  = 0;
            m_done = -10;
        end else if (bus.start && !was_busy) begin
            m_T   = cyc;
            m_a   = int'(bus.a_base);
            m_b   = int'(bus.b_base);
            m_len = int'(bus.len);
            m_dst = int'(bus.dst);
            m_err = (m_a + m_len > REG_COUNT) || (m_b + m_len > REG_COUNT) || (m_dst >= REG_COUNT);
            if (m_err) begin
                m_run  = 0;
                m_done = cyc;
            end else begin
                m_run  = 1;
                m_end  = (m_len == 0) ? cyc : cyc + m_len + 1;
                m_done = m_end;
                m_res  = '0;
                for (int i = 0; i < m_len; i++) m_res = m_res + regs[m_a + i] * regs[m_b + i];
            end
        end
    end

    int n_chk = 0, n_pass = 0, wr_cnt = 0, last_done = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        int c, e_rr1, e_rr2;
        bit e_wr;
        #1;
        c     = cyc;
        e_rr1 = 0;
        e_rr2 = 0;
        if (m_run && c >= m_T && c < m_T + m_len) begin
            e_rr1 = m_a + c - m_T;
            e_rr2 = m_b + c - m_T;
        end
        e_wr = m_run && (c == m_end);
        check("status busy/done/err", 64'({bus.busy, bus.done, bus.err}),
              64'({exp_busy(c), c == m_done, m_err}));
        check("read addresses", 64'({bus.read_reg1, bus.read_reg2}), 64'({6'(e_rr1), 6'(e_rr2)}));
        check("write port", 64'({bus.reg_write, bus.write_reg, bus.write_data}),
              64'({e_wr, e_wr ? 6'(m_dst) : 6'd0, e_wr ? m_res : 32'd0}));
        if (bus.done === 1'b1) last_done = c + 1;
        if (bus.reg_write === 1'b1) wr_cnt++;
    end

    task automatic load();
        @(negedge clk) pl_all = 1'b1;
        @(negedge clk) pl_all = 1'b0;
    endtask

    task automatic set_cmd(input int a, input int b, input int l, input int d);
        bus.a_base = 6'(a);
        bus.b_base = 6'(b);
        bus.len    = 6'(l);
        bus.dst    = 6'(d);
        bus.start  = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            $display("FAIL idle timeout: busy %b after %0d cycles, required 0", bus.busy, k);
        end
    endtask

    // Caller is aligned to a negedge; returns at the first idle cycle after the command.
    task automatic run(input int a, input int b, input int l, input int d);
        set_cmd(a, b, l, d);
        @(negedge clk) bus.start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        bus.start = 1'b0;
        bus.a_base = '0; bus.b_base = '0; bus.len = '0; bus.dst = '0;
        for (int i = 0; i < REG_COUNT; i++) pl_arr[i] = $urandom;
        repeat (2) @(negedge clk);
        check("reset outputs", 64'({bus.busy, bus.done, bus.err, bus.read_reg1, bus.read_reg2,
                                    bus.reg_write, bus.write_reg, bus.write_data}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            pl_arr[i]      = DW'(i + 1);
            pl_arr[8 + i]  = DW'(i + 5);
            pl_arr[44 + i] = DW'(i + 1);
        end
        pl_arr[5]  = 32'h0000_1234;
        pl_arr[32] = 32'hDEAD_BEEF;
        load();

        w0 = wr_cnt;
        run(0, 8, 4, 20);
        check("dot r20", 64'(regs[20]), 64'd70);
        check("dot done latency", 64'(last_done - m_T), 64'd6);
        check("dot write count", 64'(wr_cnt - w0), 64'd1);
        run(20, 20, 1, 21);
        check("readback after write r21", 64'(regs[21]), 64'd4900);

        pl_arr[0] = 32'hFFFF_FFFF;
        pl_arr[1] = 32'd2;
        load();
        run(0, 1, 1, 2);
        check("overflow wrap r2", 64'(regs[2]), 64'hFFFF_FFFE);

        run(0, 0, 0, 5);
        check("len0 r5", 64'(regs[5]), 64'd0);
        check("len0 done latency", 64'(last_done - m_T), 64'd1);

        w0 = wr_cnt;
        run(45, 0, 4, 10);
        check("range err flag", 64'(bus.err), 64'd1);
        check("range err done latency", 64'(last_done - m_T), 64'd1);
        repeat (3) @(negedge clk);
        check("range err write count", 64'(wr_cnt - w0), 64'd0);
        run(8, 8, 1, 12);
        check("err cleared", 64'(bus.err), 64'd0);
        check("after err r12", 64'(regs[12]), 64'd25);

        run(44, 44, 4, 44);
        check("edge range dst=src r44", 64'(regs[44]), 64'd30);

        pl_arr[0] = 32'd1;
        pl_arr[1] = 32'd2;
        load();
        w0 = wr_cnt;
        set_cmd(0, 8, 8, 30);
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("busy after reset", 64'(bus.busy), 64'd0);
        repeat (12) @(negedge clk);
        check("aborted run write count", 64'(wr_cnt - w0), 64'd0);
        check("aborted run r30", 64'(regs[30]), 64'(pl_arr[30]));

        w0 = wr_cnt;
        set_cmd(0, 8, 4, 31);
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk);
        set_cmd(8, 0, 4, 32);
        @(negedge clk) bus.start = 1'b0;
        wait_idle();
        check("fresh run r31", 64'(regs[31]), 64'd70);
        check("ignored start r32", 64'(regs[32]), 64'hDEAD_BEEF);
        check("fresh run write count", 64'(wr_cnt - w0), 64'd1);

        for (int it = 0; it < 60; it++) begin
            if (it % 10 == 0) begin
                for (int i = 0; i < REG_COUNT; i++) pl_arr[i] = $urandom;
                load();
            end
            if ($urandom_range(0, 7) == 0)
                set_cmd($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
            else
                set_cmd($urandom_range(0, 47), $urandom_range(0, 40), $urandom_range(0, 8), $urandom_range(0, 49));
            @(negedge clk) bus.start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                set_cmd($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 8), $urandom_range(0, 47));
                @(negedge clk) bus.start = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk) rst = 1'b1;
                @(negedge clk) rst = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
